dm_bus_master: RTL and testbench

//  CPU-side initiator for the data-memory bus. It sits in the M stage between the pipeline and the external DM/peripheral ports.

---
 rtl/mips_pkg.sv | 54 +++++
 rtl/dm_byte_lane.sv | 49 ++++
 rtl/dm_bus_master.sv | 192 +++++++++++++++++++
 tb/tb_dm_bus_master.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the M-stage data bus: op encoding, exception codes
// and the address map of DM, the two timers and the interrupt generator.
package mips_pkg;

  typedef enum logic [2:0] {
    OP_LW  = 3'd0,
    OP_LH  = 3'd1,
    OP_LHU = 3'd2,
    OP_LB  = 3'd3,
    OP_LBU = 3'd4,
    OP_SW  = 3'd5,
    OP_SH  = 3'd6,
    OP_SB  = 3'd7
  } op_e;

  typedef enum logic [2:0] {
    REG_NONE,
    REG_DM,
    REG_TMR0,
    REG_TMR1,
    REG_INT
  } region_e;

  localparam logic [4:0] EXC_NONE = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;

  localparam logic [31:0] DM_LIMIT      = 32'h0000_3000;
  localparam logic [31:0] TMR0_BASE     = 32'h0000_7F00;
  localparam logic [31:0] TMR1_BASE     = 32'h0000_7F10;
  localparam logic [31:0] INT_BASE      = 32'h0000_7F20;
  localparam logic [31:0] TMR_SIZE      = 32'd12;
  localparam logic [31:0] INT_SIZE      = 32'd4;
  localparam logic [31:0] TMR_COUNT_OFS = 32'd8;

  function automatic logic op_is_store(op_e op);
    return (op == OP_SW) || (op == OP_SH) || (op == OP_SB);
  endfunction

  function automatic region_e decode_region(logic [31:0] addr);
    region_e rg;
    rg = REG_NONE;
    if (addr < DM_LIMIT)
      rg = REG_DM;
    else if ((addr >= TMR0_BASE) && (addr < TMR0_BASE + TMR_SIZE))
      rg = REG_TMR0;
    else if ((addr >= TMR1_BASE) && (addr < TMR1_BASE + TMR_SIZE))
      rg = REG_TMR1;
    else if ((addr >= INT_BASE) && (addr < INT_BASE + INT_SIZE))
      rg = REG_INT;
    return rg;
  endfunction

endpackage

// File: rtl/dm_byte_lane.sv
// Byte-lane steering for the data bus: store byte enables and replicated
// write data, plus extraction and sign/zero extension of load data.
module dm_byte_lane
  import mips_pkg::*;
(
  input  logic [2:0]  op_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  byteen_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o
);

  op_e         op;
  logic [15:0] half_sel;
  logic [7:0]  byte_sel;

  assign op       = op_e'(op_i);
  assign half_sel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
  assign byte_sel = rdata_i[{addr_lo_i, 3'b000} +: 8];

  always_comb begin
    byteen_o = 4'b0000;
    wdata_o  = '0;
    rdata_o  = '0;
    case (op)
      OP_SW: begin
        byteen_o = 4'b1111;
        wdata_o  = wdata_i;
      end
      OP_SH: begin
        byteen_o = addr_lo_i[1] ? 4'b1100 : 4'b0011;
        wdata_o  = {2{wdata_i[15:0]}};
      end
      OP_SB: begin
        byteen_o = 4'b0001 << addr_lo_i;
        wdata_o  = {4{wdata_i[7:0]}};
      end
      OP_LW:  rdata_o = rdata_i;
      OP_LH:  rdata_o = {{16{half_sel[15]}}, half_sel};
      OP_LHU: rdata_o = {16'h0000, half_sel};
      OP_LB:  rdata_o = {{24{byte_sel[7]}}, byte_sel};
      OP_LBU: rdata_o = {24'h00_0000, byte_sel};
      default: ;
    endcase
  end

endmodule

// File: rtl/dm_bus_master.sv
// M-stage data bus initiator: accepts one load/store, screens it for
// address exceptions, runs a single bus cycle and returns a response strobe.
module dm_bus_master
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [2:0]  req_op_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  input  logic [31:0] req_pc_i,
  output logic        rsp_valid_o,
  output logic [31:0] rsp_rdata_o,
  output logic [4:0]  rsp_exc_o,
  output logic [31:0] m_data_addr_o,
  output logic [31:0] m_data_wdata_o,
  output logic [3:0]  m_data_byteen_o,
  input  logic [31:0] m_data_rdata_i,
  output logic [31:0] m_inst_addr_o,
  output logic [31:0] m_int_addr_o,
  output logic [3:0]  m_int_byteen_o,
  output logic [31:0] tmr_addr_o,
  output logic        tmr_sel_o,
  output logic        tmr_we_o,
  input  logic [31:0] tmr_rdata_i
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_RESP
  } state_e;

  state_e      state_q, state_d;
  logic [2:0]  op_q, op_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] pc_q, pc_d;
  logic [4:0]  exc_q, exc_d;
  logic [31:0] rdata_q, rdata_d;

  logic [4:0]  req_exc;
  region_e     region;
  logic        is_store;
  logic [31:0] sel_rdata;
  logic [3:0]  lane_byteen;
  logic [31:0] lane_wdata;
  logic [31:0] lane_rdata;

  function automatic logic [4:0] check_exc(logic [2:0] op_raw, logic [31:0] addr);
    op_e     op;
    region_e rg;
    logic    is_tmr;
    logic    bad;
    logic [31:0] tmr_ofs;
    op      = op_e'(op_raw);
    rg      = decode_region(addr);
    is_tmr  = (rg == REG_TMR0) || (rg == REG_TMR1);
    tmr_ofs = addr - ((rg == REG_TMR1) ? TMR1_BASE : TMR0_BASE);
    bad     = (rg == REG_NONE);
    case (op)
      OP_LW, OP_SW:        bad = bad | (addr[1:0] != 2'b00);
      OP_LH, OP_LHU, OP_SH: bad = bad | addr[0] | is_tmr;
      default:             bad = bad | is_tmr;
    endcase
    // COUNT is read-only; only a word store can reach a timer at all.
    if ((op == OP_SW) && is_tmr && (tmr_ofs == TMR_COUNT_OFS))
      bad = 1'b1;
    if (!bad)
      return EXC_NONE;
    return op_is_store(op) ? EXC_ADES : EXC_ADEL;
  endfunction

  assign req_exc  = check_exc(req_op_i, req_addr_i);
  assign region   = decode_region(addr_q);
  assign is_store = op_is_store(op_e'(op_q));

  always_comb begin
    sel_rdata = '0;
    case (region)
      REG_DM:             sel_rdata = m_data_rdata_i;
      REG_TMR0, REG_TMR1: sel_rdata = tmr_rdata_i;
      default:            sel_rdata = '0;
    endcase
  end

  dm_byte_lane u_byte_lane (
    .op_i      (op_q),
    .addr_lo_i (addr_q[1:0]),
    .wdata_i   (wdata_q),
    .rdata_i   (sel_rdata),
    .byteen_o  (lane_byteen),
    .wdata_o   (lane_wdata),
    .rdata_o   (lane_rdata)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      op_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      pc_q    <= '0;
      exc_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      pc_q    <= pc_d;
      exc_q   <= exc_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    pc_d    = pc_q;
    exc_d   = exc_q;
    rdata_d = rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid_i) begin
          op_d    = req_op_i;
          addr_d  = req_addr_i;
          wdata_d = req_wdata_i;
          pc_d    = req_pc_i;
          exc_d   = req_exc;
          rdata_d = '0;
          state_d = (req_exc != EXC_NONE) ? ST_RESP : ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        if (!is_store)
          rdata_d = lane_rdata;
        state_d = ST_RESP;
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // m_data_wdata is the one write-data bus, so timer and INT stores use it too.
  always_comb begin
    req_ready_o     = (state_q == ST_IDLE);
    rsp_valid_o     = 1'b0;
    rsp_rdata_o     = '0;
    rsp_exc_o       = '0;
    m_data_addr_o   = '0;
    m_data_wdata_o  = '0;
    m_data_byteen_o = 4'b0000;
    m_inst_addr_o   = '0;
    m_int_addr_o    = '0;
    m_int_byteen_o  = 4'b0000;
    tmr_addr_o      = '0;
    tmr_sel_o       = 1'b0;
    tmr_we_o        = 1'b0;
    if (state_q == ST_RESP) begin
      rsp_valid_o = 1'b1;
      rsp_rdata_o = rdata_q;
      rsp_exc_o   = exc_q;
    end
    if (state_q == ST_ACCESS) begin
      m_inst_addr_o = pc_q;
      if (is_store)
        m_data_wdata_o = lane_wdata;
      case (region)
        REG_DM: begin
          m_data_addr_o   = addr_q;
          m_data_byteen_o = lane_byteen;
        end
        REG_TMR0, REG_TMR1: begin
          tmr_addr_o = addr_q;
          tmr_sel_o  = (region == REG_TMR1);
          tmr_we_o   = is_store;
        end
        REG_INT: begin
          m_int_addr_o   = addr_q;
          m_int_byteen_o = lane_byteen;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dm_bus_master.sv
// Self-checking bench for dm_bus_master: directed scenarios followed by
// random traffic scored against a byte-level memory/address-map model.
module tb_dm_bus_master;

  logic        clk = 1'b0;
  logic        reset;
  logic        reqValid;
  logic        reqReady;
  logic [2:0]  reqOp;
  logic [31:0] reqAddr;
  logic [31:0] reqWdata;
  logic [31:0] reqPc;
  logic        rspValid;
  logic [31:0] rspRdata;
  logic [4:0]  rspExc;
  logic [31:0] mDataAddr;
  logic [31:0] mDataWdata;
  logic [3:0]  mDataByteen;
  logic [31:0] mDataRdata;
  logic [31:0] mInstAddr;
  logic [31:0] mIntAddr;
  logic [3:0]  mIntByteen;
  logic [31:0] tmrAddr;
  logic        tmrSel;
  logic        tmrWe;
  logic [31:0] tmrRdata;

  int errorCount = 0;
  int checkCount = 0;
  logic [31:0] lastRdata;

  always #5 clk = ~clk;

  dm_bus_master dut (
    .clk             (clk),
    .reset           (reset),
    .req_valid_i     (reqValid),
    .req_ready_o     (reqReady),
    .req_op_i        (reqOp),
    .req_addr_i      (reqAddr),
    .req_wdata_i     (reqWdata),
    .req_pc_i        (reqPc),
    .rsp_valid_o     (rspValid),
    .rsp_rdata_o     (rspRdata),
    .rsp_exc_o       (rspExc),
    .m_data_addr_o   (mDataAddr),
    .m_data_wdata_o  (mDataWdata),
    .m_data_byteen_o (mDataByteen),
    .m_data_rdata_i  (mDataRdata),
    .m_inst_addr_o   (mInstAddr),
    .m_int_addr_o    (mIntAddr),
    .m_int_byteen_o  (mIntByteen),
    .tmr_addr_o      (tmrAddr),
    .tmr_sel_o       (tmrSel),
    .tmr_we_o        (tmrWe),
    .tmr_rdata_i     (tmrRdata)
  );

  // System memory model answering the bus: combinational read, posedge write.
  logic [31:0] dmMem [0:3071] = '{default: 32'h0};
  logic [31:0] tmrRegs [0:5] = '{32'h0, 32'h0, 32'hC0FF_EE00, 32'h0, 32'h0, 32'h1234_5678};
  logic [2:0]  tmrIdx;

  assign tmrIdx     = (tmrSel ? 3'd3 : 3'd0) + {1'b0, tmrAddr[3:2]};
  assign mDataRdata = (mDataAddr < 32'h3000) ? dmMem[mDataAddr[13:2]] : 32'hDEAD_BEEF;
  assign tmrRdata   = (tmrAddr[3:2] != 2'b11) ? tmrRegs[tmrIdx] : 32'h0;

  always @(posedge clk) begin
    if (mDataAddr < 32'h3000)
      for (int b = 0; b < 4; b++)
        if (mDataByteen[b])
          dmMem[mDataAddr[13:2]][8*b +: 8] <= mDataWdata[8*b +: 8];
    if (tmrWe && (tmrAddr[3:2] != 2'b11))
      tmrRegs[tmrIdx] <= mDataWdata;
  end

  // Reference state: DM as plain bytes, timers as six words.
  logic [7:0]  refBytes [0:12287];
  logic [31:0] refTmr [0:5];

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  function automatic int sizeOf(input logic [2:0] op);
    case (op)
      3'd0, 3'd5:       return 4;
      3'd1, 3'd2, 3'd6: return 2;
      default:          return 1;
    endcase
  endfunction

  // 0 none, 1 DM, 2 Timer0, 3 Timer1, 4 interrupt generator
  function automatic int regionOf(input logic [31:0] a);
    if (a < 32'h3000) return 1;
    if (a >= 32'h7F00 && a < 32'h7F0C) return 2;
    if (a >= 32'h7F10 && a < 32'h7F1C) return 3;
    if (a >= 32'h7F20 && a < 32'h7F24) return 4;
    return 0;
  endfunction

  task automatic modelRequest(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                              output logic [4:0] exc, output int rg, output logic [3:0] be,
                              output logic [31:0] wrep, output logic [31:0] rd);
    int size;
    bit isStore, signedLoad, isTmr, bad;
    logic [31:0] word, mask, val, base;
    logic [3:0] lanes;
    int al;
    isStore    = (op >= 3'd5);
    signedLoad = (op == 3'd1) || (op == 3'd3);
    size       = sizeOf(op);
    rg         = regionOf(addr);
    isTmr      = (rg == 2) || (rg == 3);
    base       = (rg == 3) ? 32'h7F10 : 32'h7F00;
    bad = (rg == 0) || ((addr % size) != 0) || (isTmr && size != 4) ||
          (isStore && isTmr && (addr - base) == 32'd8);
    exc  = bad ? (isStore ? 5'd5 : 5'd4) : 5'd0;
    be   = 4'b0;
    wrep = 32'h0;
    rd   = 32'h0;
    if (bad) return;
    if (isStore) begin
      lanes = 4'((1 << size) - 1);
      be    = lanes << addr[1:0];
      if (size == 4)      wrep = wdata;
      else if (size == 2) wrep = {16'h0, wdata[15:0]} * 32'h0001_0001;
      else                wrep = {24'h0, wdata[7:0]} * 32'h0101_0101;
    end else begin
      if (rg == 1) begin
        al   = int'(addr & ~32'h3);
        word = {refBytes[al+3], refBytes[al+2], refBytes[al+1], refBytes[al]};
      end else if (isTmr) begin
        word = refTmr[(rg - 2) * 3 + int'((addr - base) >> 2)];
      end else begin
        word = 32'h0;
      end
      mask = (size == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * size)) - 32'h1);
      val  = (word >> (8 * addr[1:0])) & mask;
      if (signedLoad && val[8*size-1]) val = val | ~mask;
      rd = val;
    end
  endtask

  task automatic refStore(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wdata);
    int rg, size;
    rg   = regionOf(addr);
    size = sizeOf(op);
    if (rg == 1)
      for (int i = 0; i < size; i++) refBytes[int'(addr) + i] = wdata[8*i +: 8];
    else if (rg == 2 || rg == 3)
      refTmr[(rg - 2) * 3 + int'((addr - ((rg == 3) ? 32'h7F10 : 32'h7F00)) >> 2)] = wdata;
  endtask

  task automatic applyStimulus(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [31:0] pc);
    logic [4:0]  eExc;
    int          rg;
    logic [3:0]  eBe;
    logic [31:0] eWd, eRd;
    bit isStore, isTmr;
    modelRequest(op, addr, wdata, eExc, rg, eBe, eWd, eRd);
    isStore  = (op >= 3'd5);
    isTmr    = (rg == 2) || (rg == 3);
    reqValid = 1'b1;
    reqOp    = op;
    reqAddr  = addr;
    reqWdata = wdata;
    reqPc    = pc;
    @(posedge clk);
    @(negedge clk);
    reqValid = 1'b0;
    reqOp    = 3'd0;
    reqAddr  = 32'h0;
    reqWdata = 32'h0;
    reqPc    = 32'h0;
    checkOutput("busy_ready", reqReady, 0);
    if (eExc != 5'd0) begin
      checkOutput("exc_rsp_valid", rspValid, 1);
      checkOutput("exc_code", rspExc, eExc);
      checkOutput("exc_rdata", rspRdata, 0);
      checkOutput("exc_no_write", {mDataByteen, mIntByteen, tmrWe}, 0);
      lastRdata = rspRdata;
    end else begin
      checkOutput("acc_rsp_valid", rspValid, 0);
      checkOutput("acc_inst_addr", mInstAddr, pc);
      checkOutput("acc_data_addr", mDataAddr, (rg == 1) ? addr : 32'h0);
      checkOutput("acc_data_byteen", mDataByteen, (rg == 1) ? eBe : 4'h0);
      checkOutput("acc_wdata", mDataWdata, eWd);
      checkOutput("acc_int_addr", mIntAddr, (rg == 4) ? addr : 32'h0);
      checkOutput("acc_int_byteen", mIntByteen, (rg == 4) ? eBe : 4'h0);
      checkOutput("acc_tmr_addr", tmrAddr, isTmr ? addr : 32'h0);
      checkOutput("acc_tmr_sel", tmrSel, rg == 3);
      checkOutput("acc_tmr_we", tmrWe, isTmr && isStore);
      @(posedge clk);
      @(negedge clk);
      checkOutput("rsp_valid", rspValid, 1);
      checkOutput("rsp_exc", rspExc, 0);
      checkOutput("rsp_rdata", rspRdata, eRd);
      checkOutput("rsp_bus_quiet", {mDataByteen, mIntByteen, tmrWe, mDataAddr}, 0);
      lastRdata = rspRdata;
      if (isStore) refStore(op, addr, wdata);
    end
    @(posedge clk);
    @(negedge clk);
    checkOutput("idle_rsp_valid", rspValid, 0);
    checkOutput("idle_ready", reqReady, 1);
  endtask

  function automatic logic [31:0] randomAddr(input logic [2:0] op);
    logic [31:0] a;
    int size;
    size = sizeOf(op);
    case ($urandom_range(0, 9))
      0, 1, 2, 3: a = 32'($urandom_range(0, 63));
      4:          a = 32'h2FF0 + 32'($urandom_range(0, 15));
      5:          a = 32'h7F00 + 32'($urandom_range(0, 15));
      6:          a = 32'h7F10 + 32'($urandom_range(0, 15));
      7:          a = 32'h7F20 + 32'($urandom_range(0, 7));
      8:          a = ($urandom_range(0, 1) == 0) ? 32'h3000 + 32'($urandom_range(0, 255)) : ($urandom | 32'h8000_0000);
      default:    a = 32'($urandom_range(0, 15)) * 32'd4;
    endcase
    if ($urandom_range(0, 3) != 0) a = a & ~(32'(size) - 32'd1);
    return a;
  endfunction

  initial begin
    for (int i = 0; i < 12288; i++) refBytes[i] = 8'h00;
    refTmr   = '{32'h0, 32'h0, 32'hC0FF_EE00, 32'h0, 32'h0, 32'h1234_5678};
    lastRdata = 32'h0;
    reset    = 1'b0;
    reqValid = 1'b0;
    reqOp    = 3'd0;
    reqAddr  = 32'h0;
    reqWdata = 32'h0;
    reqPc    = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_ready", reqReady, 1);
    checkOutput("reset_rsp", {rspValid, rspExc, rspRdata}, 0);
    checkOutput("reset_bus", {mDataByteen, mIntByteen, tmrWe, tmrSel, mDataAddr}, 0);
    reset = 1'b1;
    @(negedge clk);

    $display("[TB] directed scenarios");
    applyStimulus(3'd7, 32'h1001, 32'h0000_00AB, 32'h0040_0010);
    applyStimulus(3'd5, 32'h0000, 32'h8001_1234, 32'h0040_0014);
    applyStimulus(3'd1, 32'h0002, 32'h0, 32'h0040_0018);
    checkOutput("spec_lh", lastRdata, 32'hFFFF_8001);
    applyStimulus(3'd2, 32'h0002, 32'h0, 32'h0040_001C);
    checkOutput("spec_lhu", lastRdata, 32'h0000_8001);
    applyStimulus(3'd4, 32'h0000, 32'h0, 32'h0040_0020);
    checkOutput("spec_lbu", lastRdata, 32'h0000_0034);
    applyStimulus(3'd0, 32'h0003, 32'h0, 32'h0040_0024);
    applyStimulus(3'd5, 32'h7F08, 32'h1111_2222, 32'h0040_0028);
    applyStimulus(3'd5, 32'h7F14, 32'h0000_0064, 32'h0040_002C);
    applyStimulus(3'd0, 32'h7F14, 32'h0, 32'h0040_0030);
    applyStimulus(3'd5, 32'h7F20, 32'h0000_0001, 32'h0040_0034);
    applyStimulus(3'd0, 32'h3000, 32'h0, 32'h0040_0038);

    $display("[TB] reset during ACCESS");
    reqValid = 1'b1;
    reqOp    = 3'd5;
    reqAddr  = 32'h0010;
    reqWdata = 32'hCAFE_F00D;
    reqPc    = 32'h0040_0100;
    @(posedge clk);
    @(negedge clk);
    reqValid = 1'b0;
    checkOutput("rst_acc_byteen", mDataByteen, 4'hF);
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checkOutput("rst_byteen", mDataByteen, 0);
    checkOutput("rst_rsp_valid", rspValid, 0);
    checkOutput("rst_ready", reqReady, 1);
    reset = 1'b1;
    refStore(3'd5, 32'h0010, 32'hCAFE_F00D);
    @(negedge clk);
    checkOutput("rst_still_idle", {rspValid, mDataByteen}, 0);
    applyStimulus(3'd0, 32'h0010, 32'h0, 32'h0040_0104);
    checkOutput("rst_recover_lw", lastRdata, 32'hCAFE_F00D);

    $display("[TB] random traffic");
    for (int n = 0; n < 300; n++) begin
      logic [2:0] op;
      op = 3'($urandom_range(0, 7));
      applyStimulus(op, randomAddr(op), $urandom, $urandom & 32'hFFFF_FFFC);
    end

    $display("[TB] Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
